// File: rtl/des_pkg.sv
// Shared definitions for the DES/LFSR Feistel datapath output stages.
// des_merge is the single place that defines the final-swap ordering so
// every stage that needs it produces the same word layout.
package des_pkg;

    localparam int HALF_W  = 32;
    localparam int BLOCK_W = 2 * HALF_W;

    // swap_mode encoding, sampled alongside a push
    localparam logic SWAP_FINAL = 1'b1;
    localparam logic SWAP_NONE  = 1'b0;

    // Final swap puts the right half in the upper word; pass-through keeps
    // the round ordering for debug/intermediate captures.
    function automatic logic [BLOCK_W-1:0] des_merge(
        input logic [HALF_W-1:0] left,
        input logic [HALF_W-1:0] right,
        input logic              swap
    );
        return (swap == SWAP_NONE) ? {left, right} : {right, left};
    endfunction

endpackage

// File: rtl/des_sync_fifo.sv
// Generic synchronous FIFO: DEPTH entries of WIDTH bits.
// Pushes while full and pops while empty are ignored here; the caller
// decides what such an attempt means. DEPTH must be a power of two >= 2 so
// the pointers wrap on their own.
//
// occupancy | meaning
// EMPTY     | count == 0, rdata is stale storage
// PARTIAL   | 0 < count < DEPTH
// FULL      | count == DEPTH, pushes ignored
module des_sync_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage is not reset; contents are only visible behind a valid count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/des_output_fifo.sv
// Output stage of the Feistel datapath: merges the final halves (with or
// without the DES final swap), queues the block with its tag and hands it
// downstream over valid/ready. A load that finds the queue full is dropped
// and latched in a sticky overflow flag.
module des_output_fifo
    import des_pkg::*;
#(
    parameter int HALF_W = des_pkg::HALF_W,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    localparam int WORD_W = 2 * HALF_W,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              swap_en,
    input  logic [HALF_W-1:0] left_in,
    input  logic [HALF_W-1:0] right_in,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              in_ready,
    output logic [WORD_W-1:0] data_out,
    output logic [TAG_W-1:0]  tag_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    input  logic              clr_ovf
);

    logic [WORD_W-1:0]       merged;
    logic [WORD_W+TAG_W-1:0] head;
    logic                    full;
    logic                    empty;

    // The shared helper is sized for the standard half width; other widths
    // use the same ordering written out directly.
    if (HALF_W == des_pkg::HALF_W) begin : g_merge_pkg
        assign merged = des_merge(left_in, right_in, swap_en);
    end else begin : g_merge_local
        assign merged = (swap_en == SWAP_FINAL) ? {right_in, left_in}
                                                : {left_in, right_in};
    end

    des_sync_fifo #(
        .WIDTH (WORD_W + TAG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (load),
        .pop   (out_ready),
        .wdata ({merged, tag_in}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Flags come straight from the registered count, so neither load nor
    // out_ready can reach in_ready/out_valid combinationally.
    assign in_ready  = !full;
    assign out_valid = !empty;

    // Hide stale storage whenever nothing is queued.
    assign data_out = out_valid ? head[WORD_W+TAG_W-1:TAG_W] : '0;
    assign tag_out  = out_valid ? head[TAG_W-1:0] : '0;

    // Sticky overflow; a new drop in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (load && full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule
